// File: rtl/spi_word_rx.sv
// SPI slave word receiver: MSB-first MOSI frames under active-low CSn, sampled on SCL falling edges.
// Optional reply path (MISO, tx_reply) is enabled by defining SPIWORD_RX_MISO_EN.
module spi_word_rx #(
    parameter int unsigned WIDTH       = 24,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             SCL,
    input  logic             CSn,
    input  logic             MOSI,
    output logic [WIDTH-1:0] rx,
    output logic             rx_valid,
    input  logic             rx_ack,
    output logic             frame_err,
    output logic             overrun,
    output logic             busy
`ifdef SPIWORD_RX_MISO_EN
    ,
    input  logic [WIDTH-1:0] tx_reply,
    output logic             MISO
`endif
);

    localparam int unsigned CW = $clog2(WIDTH + 1);
    localparam int unsigned FW = $clog2(SYNC_STAGES + 1);

    typedef enum logic [1:0] {StWait, StIdle, StShift} state_e;

    logic [1:0]             rst_sync_q;
    logic                   rst_n;
    logic [SYNC_STAGES-1:0] scl_sync, csn_sync, mosi_sync;
    logic                   scl_q;
    logic                   scl_s, csn_s, mosi_s;
    logic                   scl_fall, sample, last;

    state_e                 state_q;
    logic [CW-1:0]          cnt_q;
    logic [FW-1:0]          flush_q;
    logic [WIDTH-1:0]       shift_q;
    logic                   done_q;
    logic                   pending_q;
    logic [WIDTH-1:0]       rx_q;
    logic                   rx_valid_q, frame_err_q, overrun_q;

    // Assert asynchronously, release on a clock edge.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) rst_sync_q <= 2'b00;
        else         rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_n = rst_sync_q[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_sync  <= '1;
            csn_sync  <= '1;
            mosi_sync <= '0;
            scl_q     <= 1'b1;
        end else begin
            scl_sync[0]  <= SCL;
            csn_sync[0]  <= CSn;
            mosi_sync[0] <= MOSI;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                scl_sync[i]  <= scl_sync[i-1];
                csn_sync[i]  <= csn_sync[i-1];
                mosi_sync[i] <= mosi_sync[i-1];
            end
            scl_q <= scl_s;
        end
    end

    assign scl_s    = scl_sync[SYNC_STAGES-1];
    assign csn_s    = csn_sync[SYNC_STAGES-1];
    assign mosi_s   = mosi_sync[SYNC_STAGES-1];
    assign scl_fall = scl_q & ~scl_s;
    assign sample   = scl_fall & ~csn_s & (state_q != StWait);
    assign last     = (cnt_q == CW'(WIDTH - 1));

    // StWait lets the preset synchronisers flush after reset and then demands a
    // high CSn, so a frame already in progress at reset release is never joined.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StWait;
            cnt_q       <= '0;
            flush_q     <= '0;
            shift_q     <= '0;
            done_q      <= 1'b0;
            pending_q   <= 1'b0;
            rx_q        <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            rx_valid_q  <= done_q;
            frame_err_q <= 1'b0;
            done_q      <= 1'b0;

            if (rx_ack) begin
                pending_q <= 1'b0;
                overrun_q <= 1'b0;
            end
            // A completion beats a coincident ack: the new word stays pending.
            if (done_q) begin
                rx_q      <= shift_q;
                pending_q <= 1'b1;
                if (pending_q && !rx_ack) overrun_q <= 1'b1;
            end

            case (state_q)
                StWait: begin
                    if (flush_q != FW'(SYNC_STAGES)) flush_q <= flush_q + FW'(1);
                    else if (csn_s)                  state_q <= StIdle;
                end
                StIdle: begin
                    if (!csn_s) state_q <= StShift;
                end
                StShift: begin
                    if (csn_s) begin
                        state_q     <= StIdle;
                        frame_err_q <= (cnt_q != '0);
                    end
                end
                default: state_q <= StWait;
            endcase

            if (csn_s) begin
                cnt_q <= '0;
            end else if (sample) begin
                shift_q <= {shift_q[WIDTH-2:0], mosi_s};
                if (last) begin
                    cnt_q  <= '0;
                    done_q <= 1'b1;
                end else begin
                    cnt_q <= cnt_q + CW'(1);
                end
            end
        end
    end

    assign rx        = rx_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
    assign busy      = ~csn_s & (cnt_q != '0);

`ifdef SPIWORD_RX_MISO_EN
    logic [WIDTH-1:0] reply_q, reply_cur;
    logic             miso_q;

    // Reply is (re)loaded on the first cycle CSn is seen low, and at each completion.
    always_comb begin
        reply_cur = reply_q;
        if (state_q == StIdle) reply_cur = tx_reply;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reply_q <= '0;
            miso_q  <= 1'b0;
        end else if (csn_s || state_q == StWait) begin
            miso_q <= 1'b0;
        end else if (sample) begin
            miso_q  <= reply_cur[WIDTH-1];
            reply_q <= last ? tx_reply : {reply_cur[WIDTH-2:0], 1'b0};
        end else begin
            reply_q <= reply_cur;
        end
    end

    assign MISO = miso_q;
`endif

endmodule

// File: tb/tb_spi_word_rx.sv
// Bench for spi_word_rx: transmitter model at clk/2, received words scored against a queue.
module tb_spi_word_rx;

    localparam int W = 24;
    localparam int S = 2;

    logic         clk    = 1'b0;
    logic         resetn = 1'b1;
    logic         SCL    = 1'b1;
    logic         CSn    = 1'b1;
    logic         MOSI   = 1'b0;
    logic         rx_ack = 1'b0;
    logic [W-1:0] rx;
    logic         rx_valid, frame_err, overrun, busy;
`ifdef SPIWORD_RX_MISO_EN
    logic [W-1:0] tx_reply = '0;
    logic         MISO;
    logic [W-1:0] miso_cap = '0;
`endif

    int           n_tests = 0;
    int           n_fail  = 0;
    int           n_valid = 0;
    int           n_ferr  = 0;
    logic [W-1:0] sb[$];

    always #5 clk = ~clk;

    spi_word_rx #(
        .WIDTH       (W),
        .SYNC_STAGES (S)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .SCL       (SCL),
        .CSn       (CSn),
        .MOSI      (MOSI),
        .rx        (rx),
        .rx_valid  (rx_valid),
        .rx_ack    (rx_ack),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy)
`ifdef SPIWORD_RX_MISO_EN
        ,
        .tx_reply  (tx_reply),
        .MISO      (MISO)
`endif
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rx_valid) begin
            n_valid++;
            check_eq("sb_nonempty", 32'(sb.size() != 0), 1);
            if (sb.size() != 0) check_eq("rx_word", rx, sb.pop_front());
        end
        if (frame_err) n_ferr++;
    end

    task automatic cs_low();
        @(negedge clk);
        CSn = 1'b0;
        @(negedge clk);
    endtask

    task automatic cs_high();
        @(negedge clk);
        CSn = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    // MOSI changes with SCL rising and holds through the low phase.
    task automatic send_bits(input logic [W-1:0] d, input int n, input int hp);
        for (int i = 0; i < n; i++) begin
            MOSI = d[W-1-i];
            repeat (hp) @(negedge clk);
            SCL = 1'b0;
            repeat (hp) @(negedge clk);
`ifdef SPIWORD_RX_MISO_EN
            miso_cap = {miso_cap[W-2:0], MISO};
`endif
            SCL = 1'b1;
        end
    endtask

    // Full frame; times rx_valid from the last SCL fall and optionally acks on the load edge.
    task automatic send_frame(input logic [W-1:0] d, input int ack_k, output int lat);
        sb.push_back(d);
        cs_low();
        send_bits(d, W - 1, 1);
        MOSI = d[0];
        @(negedge clk);
        SCL = 1'b0;
        lat = 0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 1) SCL = 1'b1;
            if (rx_valid && lat == 0) lat = k;
            rx_ack = (k == ack_k);
        end
        rx_ack = 1'b0;
        cs_high();
    endtask

    task automatic ack();
        @(negedge clk);
        rx_ack = 1'b1;
        @(negedge clk);
        rx_ack = 1'b0;
    endtask

    initial begin
        int   lat, v0, f0;
        logic sawbusy;

        #2 resetn = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_rx", rx, 0);
        check_eq("rst_valid", rx_valid, 0);
        check_eq("rst_ferr", frame_err, 0);
        check_eq("rst_ovr", overrun, 0);
        check_eq("rst_busy", busy, 0);
        resetn = 1'b1;
        repeat (8) @(negedge clk);

        // Single frame, with latency check.
        v0 = n_valid; f0 = n_ferr;
        send_frame(24'hA5C35A, 0, lat);
        check_eq("t1_latency", lat, S + 2);
        check_eq("t1_valid_cnt", n_valid - v0, 1);
        check_eq("t1_ferr_cnt", n_ferr - f0, 0);
        check_eq("t1_ovr", overrun, 0);
        check_eq("t1_rx", rx, 24'hA5C35A);
        check_eq("t1_busy", busy, 0);
        ack();

        // Back-to-back words under one CSn, no ack.
        v0 = n_valid;
        sb.push_back(24'h000001);
        sb.push_back(24'hFFFFFE);
        cs_low();
        send_bits(24'h000001, 24, 1);
        send_bits(24'hFFFFFE, 24, 1);
        cs_high();
        check_eq("t2_valid_cnt", n_valid - v0, 2);
        check_eq("t2_rx", rx, 24'hFFFFFE);
        check_eq("t2_ovr_set", overrun, 1);
        ack();
        check_eq("t2_ovr_clr", overrun, 0);

        // Ack coinciding with a completion: completion wins, pending stays set.
        send_frame(24'h111111, 0, lat);
        send_frame(24'h222222, 3, lat);
        check_eq("ack_coincide_ovr", overrun, 0);
        send_frame(24'h333333, 0, lat);
        check_eq("ack_coincide_pending", overrun, 1);
        ack();
        check_eq("ack_clr_ovr", overrun, 0);

        // Short frame.
        v0 = n_valid; f0 = n_ferr;
        cs_low();
        send_bits(24'h123456, 10, 1);
        check_eq("t3_busy_mid", busy, 1);
        cs_high();
        check_eq("t3_ferr_cnt", n_ferr - f0, 1);
        check_eq("t3_valid_cnt", n_valid - v0, 0);
        check_eq("t3_rx_kept", rx, 24'h333333);
        send_frame(24'h00FF00, 0, lat);
        check_eq("t3_rx_next", rx, 24'h00FF00);

        // SCL activity with CSn high.
        v0 = n_valid;
        sawbusy = 1'b0;
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            SCL = 1'b0;
            if (busy) sawbusy = 1'b1;
            @(negedge clk);
            SCL = 1'b1;
            if (busy) sawbusy = 1'b1;
        end
        repeat (6) @(negedge clk);
        check_eq("t4_busy", sawbusy, 0);
        check_eq("t4_valid_cnt", n_valid - v0, 0);
        send_frame(24'h0F0F0F, 0, lat);
        check_eq("t4_rx", rx, 24'h0F0F0F);
        check_eq("t4_ovr", overrun, 1);

        // Reset mid-frame, then stray bits before a fresh CSn fall.
        f0 = n_ferr;
        cs_low();
        send_bits(24'hABCDEF, 12, 1);
        check_eq("t5_busy_mid", busy, 1);
        @(negedge clk);
        resetn = 1'b0;
        #1;
        check_eq("t5_rx_clr", rx, 0);
        check_eq("t5_ovr_clr", overrun, 0);
        check_eq("t5_busy_clr", busy, 0);
        check_eq("t5_valid_clr", rx_valid, 0);
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        repeat (8) @(negedge clk);
        v0 = n_valid;
        send_bits(24'hFFFFFF, 8, 1);
        repeat (4) @(negedge clk);
        check_eq("t5_no_resync_busy", busy, 0);
        cs_high();
        check_eq("t5_ferr_cnt", n_ferr - f0, 0);
        check_eq("t5_valid_cnt", n_valid - v0, 0);
        send_frame(24'h800001, 0, lat);
        check_eq("t5_rx", rx, 24'h800001);
        ack();

`ifdef SPIWORD_RX_MISO_EN
        tx_reply = 24'hC0FFEE;
        miso_cap = '0;
        sb.push_back(24'h5A5A5A);
        cs_low();
        send_bits(24'h5A5A5A, 24, 4);
        check_eq("miso_reply", miso_cap, 24'hC0FFEE);
        cs_high();
        check_eq("miso_idle", MISO, 0);
        check_eq("miso_rx", rx, 24'h5A5A5A);
`endif

        check_eq("sb_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_word_rx.md
Name: spi_word_rx

Overview:
- SPI slave-side word receiver; the far end of our 24-bit SPI word transmitter.
- Deserialises MSB-first MOSI frames framed by active-low CS, all in the system clk domain.
- Presents each complete word on a parallel port with a one-cycle valid strobe.
- Flags frames that end short or overrun unread data.
- Sits behind board pins or an on-chip loopback, feeding config registers or a FIFO.

Parameters:
- WIDTH, 24: bits per frame; range 8..32.
- SYNC_STAGES, 2: flops per input synchroniser on SCL, CSn, MOSI; minimum 1 for on-chip loopback, 2 or more for pins.

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- SCL  in  1  SPI clock; idles high
- CSn  in  1  chip select, active low
- MOSI  in  1  serial data, MSB first
- rx  out  WIDTH  last complete word
- rx_valid  out  1  one-cycle pulse when rx updates
- rx_ack  in  1  consumer has taken rx; clears pending
- frame_err  out  1  one-cycle pulse: CS deasserted mid-word
- overrun  out  1  sticky: new word arrived while previous unacked; cleared by rx_ack
- busy  out  1  CS asserted and at least one bit captured

Behaviour:
- Reset: all outputs 0; bit counter 0; pending 0; synchronisers preset to idle (SCL=1, CSn=1, MOSI=0). resetn is asynchronous in assertion; its release is synchronous to clk.
- Inputs pass through SYNC_STAGES flops. Edge detect compares the last synchronised stage with one extra registered copy.
- Sample point:
  - A bit is taken on the cycle synchronised SCL is first seen 0 after 1 (falling edge), while synchronised CSn=0.
  - MOSI is taken from the same synchronised stage as SCL.
  - This matches our transmitter, which changes MOSI together with SCL rising and holds it through the low phase.
  - SCL may run at clk/2 when sourced from the same clk domain. Asynchronous sources must keep SCL at or below clk/4.
- States:
  - IDLE (CSn=1): counter held 0.
  - SHIFT (CSn=0): each sample shifts the bit into an LSB-entering shift register and increments the counter.
  - On the count reaching WIDTH:
    - Copy the shift register to rx next cycle; pulse rx_valid; set pending.
    - Counter returns to 0 and SHIFT continues, so back-to-back words within one CS are accepted.
- Latency: rx and rx_valid rise 1 clk after the sampling cycle of the last bit, which is SYNC_STAGES+2 clks after the pin-level SCL fall.
- The trailing SCL rise after the final bit is ignored. Rising edges never sample.
- CSn rising (synchronised):
  - If counter≠0: pulse frame_err, discard the partial word, and leave rx unchanged.
  - Counter returns to 0 in all cases.
- SCL falling while CSn=1 is ignored.
- Overrun: word completes while pending=1 → rx is overwritten, rx_valid pulses, overrun set.
- Ack: rx_ack clears pending and overrun. If rx_ack and a completion coincide, the completion wins: pending=1, overrun not set.
- busy = (CSn sync=0) and (counter≠0).
- resetn asserted mid-frame: everything clears immediately, and the partial frame is lost without frame_err. After release, the slave waits for a CSn 1→0 edge before sampling again (no mid-frame resync).

Optional Feature:
- SPIWORD_RX_MISO_EN defined:
  - Adds input tx_reply[WIDTH-1:0] and output MISO.
  - tx_reply is loaded when the synchronised CSn falls and at each word completion.
  - MISO drives the reply MSB first and shifts on each sampled SCL falling edge, so it is stable for the master at SCL rising.
  - MISO is 0 while CSn=1.
- Undefined: no MISO or tx_reply ports and no reply logic.

Test Plan:
- Reset release, then one 24-bit frame 0xA5C3_5A via a transmitter model at clk/2, CSn low 2 clks before the first SCL fall → rx=0xA5C35A, one rx_valid pulse, no frame_err, overrun=0.
- Two words 0x000001 and 0xFFFFFE under a single CSn low, no ack between → two rx_valid pulses in order, overrun=1 after the second, cleared by rx_ack.
- CSn raised after 10 bits of 0x123456 → frame_err one pulse, rx retains the previous value, no rx_valid; the next full frame 0x00FF00 is received correctly.
- SCL toggled 24 times with CSn=1 → no rx_valid, busy=0, counter stays 0.
- resetn pulsed low after 12 bits → outputs 0 immediately. A following frame 0x800001 after a fresh CSn fall → rx=0x800001.
- With SPIWORD_RX_MISO_EN, tx_reply=0xC0FFEE, send any 24-bit frame → the MISO bits captured at SCL rising form 0xC0FFEE.
